// File: rtl/bcd_serial_adder_ctrl_if.sv
// Handshake bundle for the digit-serial BCD adder: operand request channel
// in, result channel out. "slave" is the adder's view, "master" the environment's.
interface bcd_serial_adder_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   addend;
    logic [4*DIGITS-1:0]   augend;
    logic                  carry_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   sum;
    logic                  output_carry;
    logic                  digit_err;

    modport master (
        output in_valid, addend, augend, carry_in, out_ready,
        input  in_ready, out_valid, sum, output_carry, digit_err
    );

    modport slave (
        input  in_valid, addend, augend, carry_in, out_ready,
        output in_ready, out_valid, sum, output_carry, digit_err
    );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one 4-bit add + 6-correction stage reused
// over DIGITS digits, LSD first, between valid/ready operand and result channels.
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    bcd_serial_adder_ctrl_if.slave      bus
);
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W    = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      opa_q, opa_d;
    logic [W-1:0]      opb_q, opb_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              ocarry_q, ocarry_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [3:0]        dig_a;
    logic [3:0]        dig_b;
    logic [4:0]        dig_t;
    logic [3:0]        dig_sum;
    logic              dig_carry;
    logic              last_digit;

    // Shared single-digit decimal add stage, indexed by the current digit.
    always_comb begin
        dig_a      = opa_q[4*int'(idx_q) +: 4];
        dig_b      = opb_q[4*int'(idx_q) +: 4];
        dig_t      = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
        dig_carry  = (dig_t > 5'd9);
        dig_sum    = dig_carry ? 4'(dig_t + 5'd6) : dig_t[3:0];
        last_digit = (idx_q == IDXW'(DIGITS - 1));
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sum_d       = sum_q;
        ocarry_d    = ocarry_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    opa_d      = bus.addend;
                    opb_d      = bus.augend;
                    idx_d      = '0;
                    carry_d    = bus.carry_in;
                    err_d      = 1'b0;
                    sum_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sum_d[4*int'(idx_q) +: 4] = dig_sum;
                carry_d = dig_carry;
                if ((dig_a > 4'd9) || (dig_b > 4'd9)) begin
                    err_d = 1'b1;
                end
                if (last_digit) begin
                    ocarry_d    = dig_carry;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // Handshake outputs are registered alongside the state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            ocarry_q    <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sum_q       <= sum_d;
            ocarry_q    <= ocarry_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.sum          = sum_q;
    assign bus.output_carry = ocarry_q;
    assign bus.digit_err    = err_q;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Scoreboard bench for bcd_serial_adder_ctrl: directed operands push hand-computed
// results into a queue, a monitor pops and compares on each result handshake.
module tb_bcd_serial_adder_ctrl;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         err;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_serial_adder_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t sb[$];
    exp_t popped;
    int   checkCount = 0;
    int   errCount   = 0;
    int   cyc        = 0;
    logic prevValid  = 1'b0;
    int   acc0, acc1, acc2, accTmp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: latency on the rising out_valid, contents on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
        end else begin
            if (bus.out_valid && !prevValid) begin
                if (sb.size() == 0) checkOutput("unexpected_result", 64'd1, 64'd0);
                else                checkOutput("latency", 64'(cyc - sb[0].acc), 64'(DIGITS));
            end
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                popped = sb.pop_front();
                checkOutput("sum",          64'(bus.sum),          64'(popped.sum));
                checkOutput("output_carry", 64'(bus.output_carry), 64'(popped.carry));
                checkOutput("digit_err",    64'(bus.digit_err),    64'(popped.err));
            end
            prevValid = bus.out_valid;
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input logic [W-1:0] es, input logic ec, input logic ee,
                                 output int acc);
        int   n;
        exp_t e;
        n   = 0;
        acc = -1;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checkOutput("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.addend   = a;
        bus.augend   = b;
        bus.carry_in = cin;
        @(posedge clk);
        #1;
        acc          = cyc;
        bus.in_valid = 1'b0;
        bus.addend   = 16'h7777;
        bus.augend   = 16'h7777;
        bus.carry_in = 1'b1;
        e.sum   = es;
        e.carry = ec;
        e.err   = ee;
        e.acc   = acc;
        sb.push_back(e);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) checkOutput("out_valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.addend    = '0;
        bus.augend    = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(bus.out_valid),    64'd0);
        checkOutput("reset_sum",       64'(bus.sum),          64'd0);
        checkOutput("reset_carry",     64'(bus.output_carry), 64'd0);
        checkOutput("reset_err",       64'(bus.digit_err),    64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] basic, ripple and invalid-digit operations");
        applyStimulus(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, accTmp);
        applyStimulus(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, accTmp);
        applyStimulus(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, accTmp);
        applyStimulus(16'h00A5, 16'h0004, 1'b0, 16'h0109, 1'b0, 1'b1, accTmp);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, accTmp);
        waitDrain();

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, accTmp);
        waitValid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 64'(bus.out_valid),    64'd1);
            checkOutput("hold_sum",       64'(bus.sum),          64'h5432);
            checkOutput("hold_carry",     64'(bus.output_carry), 64'd0);
            checkOutput("hold_in_ready",  64'(bus.in_ready),     64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("release_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("release_in_ready",  64'(bus.in_ready),  64'd1);
        waitDrain();

        $display("[TB] busy input ignored");
        applyStimulus(16'h2500, 16'h2500, 1'b0, 16'h5000, 1'b0, 1'b0, accTmp);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.addend   = 16'h1111;
        bus.augend   = 16'h1111;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        waitDrain();
        repeat (8) @(negedge clk);
        checkOutput("no_spurious_op", 64'(bus.out_valid), 64'd0);

        $display("[TB] back-to-back throughput");
        applyStimulus(16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, acc0);
        applyStimulus(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, acc1);
        applyStimulus(16'h0123, 16'h0877, 1'b0, 16'h1000, 1'b0, 1'b0, acc2);
        checkOutput("spacing_1", 64'(acc1 - acc0), 64'(DIGITS + 2));
        checkOutput("spacing_2", 64'(acc2 - acc1), 64'(DIGITS + 2));
        waitDrain();

        $display("[TB] reset during RUN");
        applyStimulus(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, accTmp);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_in_ready",  64'(bus.in_ready),     64'd1);
        checkOutput("abort_out_valid", 64'(bus.out_valid),    64'd0);
        checkOutput("abort_sum",       64'(bus.sum),          64'd0);
        checkOutput("abort_carry",     64'(bus.output_carry), 64'd0);
        sb.delete();
        rst = 1'b0;
        applyStimulus(16'h0050, 16'h0050, 1'b0, 16'h0100, 1'b0, 1'b0, accTmp);
        waitDrain();
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
